// File: rtl/truth_table_sweep.sv
// truth_table_sweep
//
// Sweeps every 3-bit input vector through an external combinational function.
// Each vector is held for SETTLE_CYCLES clocks, and the function output is
// captured into a truth table at the last edge of that window.
//
// Parameters
//   SETTLE_CYCLES  clocks each vector is held before f is sampled (1..255)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        sweep request, accepted only while idle
//   f            output of the function under test, driven from abc
//   abc          vector presented to the function (abc[2]=A, abc[1]=B, abc[0]=C)
//   busy         high while vectors are being driven and sampled
//   done         one-cycle pulse when a sweep completes
//   truth_table  truth_table[i] = f sampled with abc=i
//   ones_count   number of vectors for which f sampled 1 (0..8)
module truth_table_sweep #(
    parameter int SETTLE_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f,
    output logic [2:0] abc,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic [3:0] ones_count
);

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] settle_cnt;
    logic       sample;
    logic       last_vec;

    // The sample edge is the last edge of a vector's settle window.
    assign sample   = (state == SETTLE) && (settle_cnt == 8'd0);
    assign last_vec = (abc == 3'b111);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (sample && last_vec) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state == SETTLE);
        done = (state == DONE);
    end

    // Vector, settle counter and captured results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abc         <= 3'b000;
            settle_cnt  <= 8'd0;
            truth_table <= 8'h00;
            ones_count  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        abc         <= 3'b000;
                        settle_cnt  <= RELOAD;
                        truth_table <= 8'h00;
                        ones_count  <= 4'd0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != 8'd0) begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end else begin
                        truth_table[abc] <= f;
                        // At most 8 samples, so 4 bits never overflow.
                        ones_count       <= ones_count + {3'b000, f};
                        // abc stays at 7 through DONE; it returns to 0 on the way to IDLE.
                        if (!last_vec) begin
                            abc        <= abc + 3'd1;
                            settle_cnt <= RELOAD;
                        end
                    end
                end
                DONE: begin
                    abc <= 3'b000;
                end
                default: begin
                    abc <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: one instance with SETTLE_CYCLES=10 and one with
// SETTLE_CYCLES=1 share clock, reset and start. Both drive f from a lookup
// table ftab indexed by their own abc. A cycle-count model predicts every
// output from the number of edges since the accepting edge.
module tb_truth_table_sweep;

    localparam int S0 = 10;
    localparam int S1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             start;
    logic [7:0]       ftab;
    logic [1:0][2:0]  abc_o;
    logic [1:0]       busy_o;
    logic [1:0]       done_o;
    logic [1:0]       f_i;
    logic [1:0][7:0]  tt_o;
    logic [1:0][3:0]  ones_o;

    assign f_i[0] = ftab[abc_o[0]];
    assign f_i[1] = ftab[abc_o[1]];

    truth_table_sweep #(.SETTLE_CYCLES(S0)) u10 (
        .clk(clk), .rst(rst), .start(start), .f(f_i[0]),
        .abc(abc_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .truth_table(tt_o[0]), .ones_count(ones_o[0])
    );

    truth_table_sweep #(.SETTLE_CYCLES(S1)) u1 (
        .clk(clk), .rst(rst), .start(start), .f(f_i[1]),
        .abc(abc_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .truth_table(tt_o[1]), .ones_count(ones_o[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_t = edges since the accepting edge, -1 when idle.
    // 0..8S-1 is the sweep, 8S is the done cycle.
    int         sv[2]    = '{S0, S1};
    int         m_t[2]   = '{-1, -1};
    logic [7:0] m_tbl[2] = '{8'h00, 8'h00};
    int         cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_t[i]   <= -1;
                m_tbl[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_t[i] < 0) begin
                    if (start) begin
                        m_t[i]   <= 0;
                        m_tbl[i] <= 8'h00;
                    end
                end else if (m_t[i] < 8 * sv[i]) begin
                    if ((m_t[i] + 1) % sv[i] == 0)
                        m_tbl[i][m_t[i] / sv[i]] <= ftab[m_t[i] / sv[i]];
                    m_t[i] <= m_t[i] + 1;
                end else begin
                    m_t[i] <= -1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus done-pulse bookkeeping.
    int done_cnt[2] = '{0, 0};
    int done_at[2]  = '{0, 0};
    int gap[2]      = '{0, 0};

    always @(negedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            logic       e_busy;
            logic       e_done;
            logic [2:0] e_abc;
            e_busy = (m_t[i] >= 0) && (m_t[i] < 8 * sv[i]);
            e_done = (m_t[i] == 8 * sv[i]);
            e_abc  = (m_t[i] < 0) ? 3'd0 : (e_busy ? 3'(m_t[i] / sv[i]) : 3'd7);
            check($sformatf("u%0d busy", i), 32'(busy_o[i]), 32'(e_busy));
            check($sformatf("u%0d done", i), 32'(done_o[i]), 32'(e_done));
            check($sformatf("u%0d abc", i), 32'(abc_o[i]), 32'(e_abc));
            check($sformatf("u%0d table", i), 32'(tt_o[i]), 32'(m_tbl[i]));
            check($sformatf("u%0d ones", i), 32'(ones_o[i]), 32'($countones(m_tbl[i])));
            if (done_o[i]) begin
                done_cnt[i] <= done_cnt[i] + 1;
                gap[i]      <= cyc - done_at[i];
                done_at[i]  <= cyc;
            end
        end
    end

    int acc = 0;

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        acc   = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int i, input int target, input int lim);
        int n = 0;
        while (done_cnt[i] < target && n < lim) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (done_cnt[i] < target) check($sformatf("u%0d done timeout", i), 32'(done_cnt[i]), 32'(target));
    endtask

    task automatic wait_abc(input int i, input logic [2:0] v, input int lim);
        int n = 0;
        while (abc_o[i] !== v && n < lim) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (abc_o[i] !== v) check($sformatf("u%0d abc timeout", i), 32'(abc_o[i]), 32'(v));
    endtask

    task automatic check_zero(input int i, input string tag);
        check({tag, " busy"}, 32'(busy_o[i]), 32'd0);
        check({tag, " done"}, 32'(done_o[i]), 32'd0);
        check({tag, " abc"}, 32'(abc_o[i]), 32'd0);
        check({tag, " table"}, 32'(tt_o[i]), 32'h00);
        check({tag, " ones"}, 32'(ones_o[i]), 32'd0);
    endtask

    initial begin
        int c0;
        logic [2:0] v;
        rst   = 1'b1;
        start = 1'b0;
        ftab  = 8'h00;
        repeat (3) @(negedge clk);
        #2;
        check_zero(0, "reset u10");
        check_zero(1, "reset u1");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: f = A&B | C
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            ftab[k] = (v[2] & v[1]) | v[0];
        end
        c0 = done_cnt[0];
        pulse_start();
        wait_done(0, c0 + 1, 200);
        check("t1 latency", 32'(done_at[0] - acc), 32'd80);
        check("t1 table", 32'(tt_o[0]), 32'hEA);
        check("t1 ones", 32'(ones_o[0]), 32'd5);
        check("t1 u1 table", 32'(tt_o[1]), 32'hEA);
        repeat (3) @(negedge clk);

        // Test 2: f constant 0, then constant 1
        ftab = 8'h00;
        c0 = done_cnt[0];
        pulse_start();
        wait_done(0, c0 + 1, 200);
        check("t2 zero table", 32'(tt_o[0]), 32'h00);
        check("t2 zero ones", 32'(ones_o[0]), 32'd0);
        repeat (3) @(negedge clk);
        ftab = 8'hFF;
        c0 = done_cnt[0];
        pulse_start();
        wait_done(0, c0 + 1, 200);
        check("t2 one table", 32'(tt_o[0]), 32'hFF);
        check("t2 one ones", 32'(ones_o[0]), 32'd8);
        check("t2 u1 ones", 32'(ones_o[1]), 32'd8);
        repeat (3) @(negedge clk);

        // Test 3: f = A^B^C on the SETTLE_CYCLES=1 instance
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            ftab[k] = v[2] ^ v[1] ^ v[0];
        end
        c0 = done_cnt[1];
        pulse_start();
        wait_done(1, c0 + 1, 50);
        check("t3 latency", 32'(done_at[1] - acc), 32'd8);
        check("t3 table", 32'(tt_o[1]), 32'h96);
        check("t3 ones", 32'(ones_o[1]), 32'd4);
        wait_done(0, done_cnt[0] + 1, 200);
        repeat (3) @(negedge clk);

        // Test 4: second start mid-sweep is ignored
        ftab = 8'($urandom);
        c0 = done_cnt[0];
        pulse_start();
        wait_abc(0, 3'd3, 100);
        pulse_start();
        wait_done(0, c0 + 1, 200);
        check("t4 table", 32'(tt_o[0]), 32'(ftab));
        repeat (100) @(negedge clk);
        #2;
        check("t4 single done", 32'(done_cnt[0] - c0), 32'd1);

        // Test 5: asynchronous reset at abc=5 aborts the sweep
        ftab = 8'($urandom);
        c0 = done_cnt[0];
        pulse_start();
        wait_abc(0, 3'd5, 100);
        #1;
        rst = 1'b1;
        #1;
        check_zero(0, "t5 async");
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        #2;
        check("t5 no done", 32'(done_cnt[0] - c0), 32'd0);
        ftab = 8'($urandom);
        pulse_start();
        wait_done(0, c0 + 1, 200);
        check("t5 table", 32'(tt_o[0]), 32'(ftab));
        check("t5 ones", 32'(ones_o[0]), 32'($countones(ftab)));
        repeat (3) @(negedge clk);

        // Test 6: start held high for three sweeps
        ftab = 8'($urandom);
        c0 = done_cnt[0];
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_done(0, c0 + k, 200);
            if (k > 1) check($sformatf("t6 gap %0d", k), 32'(gap[0]), 32'd82);
        end
        start = 1'b0;
        check("t6 table", 32'(tt_o[0]), 32'(ftab));
        repeat (5) @(negedge clk);

        // Randomized traffic: sporadic starts, function changes, resets
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) ftab = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        start = 1'b0;
        repeat (100) @(negedge clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
